// File: rtl/weight_tile_packer.sv
// rtl/weight_tile_packer.sv - packs S2P weight words per tile row from SRAM into a row FIFO toward the PE array
module weight_tile_packer #(
  parameter int S2P        = 8,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [15:0]             i_tile_total,
  input  logic [ADDR_W-1:0]       i_addr,
  input  logic                    i_addr_valid,
  input  logic                    i_pad,
  output logic                    o_gen_enable,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_rd_addr,
  input  logic [DATA_W-1:0]       mem_rd_data,
  output logic [S2P*DATA_W-1:0]   o_row_data,
  output logic                    o_row_valid,
  input  logic                    i_row_ready,
  output logic [$clog2(S2P)-1:0]  o_row_idx,
  output logic                    o_tile_last,
  output logic                    o_done,
  output logic                    o_overflow
);
  localparam int LW = $clog2(S2P);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state;
  logic [15:0]           tile_total_q;
  logic [15:0]           tile_cnt;
  logic [LW-1:0]         lane_cnt;
  logic [LW-1:0]         row_cnt;
  logic [RD_LAT-1:0]     vld_sr;
  logic [RD_LAT-1:0]     pad_sr;
  logic [S2P*DATA_W-1:0] row_buf;
  logic [S2P*DATA_W-1:0] row_next;

  logic [S2P*DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [LW-1:0]         fifo_idx  [FIFO_DEPTH];
  logic                  fifo_fin  [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         fifo_count;

  logic              run;
  logic              word_in;
  logic              word_vld;
  logic [DATA_W-1:0] word;
  logic              push_row;
  logic              push_ok;
  logic              pop;
  logic              full;
  logic              last_row;
  logic              last_tile;

  assign run         = (state == S_RUN);
  assign mem_rd_en   = i_addr_valid & ~i_pad & run;
  assign mem_rd_addr = i_addr;
  assign word_in     = i_addr_valid & run;

  // Words still in the read pipeline once the tensor is complete are discarded.
  assign word_vld  = vld_sr[RD_LAT-1] & run;
  assign word      = pad_sr[RD_LAT-1] ? '0 : mem_rd_data;
  assign push_row  = word_vld && (lane_cnt == LW'(S2P-1));
  assign last_row  = (row_cnt == LW'(S2P-1));
  assign last_tile = (tile_cnt == tile_total_q - 16'd1);

  assign full        = (fifo_count == CW'(FIFO_DEPTH));
  assign o_row_valid = (fifo_count != '0);
  assign pop         = o_row_valid & i_row_ready;
  assign push_ok     = push_row & (~full | pop);

  assign o_row_data  = o_row_valid ? fifo_data[rd_ptr] : '0;
  assign o_row_idx   = o_row_valid ? fifo_idx[rd_ptr] : '0;
  assign o_tile_last = o_row_valid & (fifo_idx[rd_ptr] == LW'(S2P-1));

  always_comb begin
    row_next = row_buf;
    row_next[lane_cnt*DATA_W +: DATA_W] = word;
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push_ok && !start) begin
      fifo_data[wr_ptr] <= row_next;
      fifo_idx[wr_ptr]  <= row_cnt;
      fifo_fin[wr_ptr]  <= last_row & last_tile;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      tile_total_q <= '0;
      tile_cnt     <= '0;
      lane_cnt     <= '0;
      row_cnt      <= '0;
      vld_sr       <= '0;
      pad_sr       <= '0;
      row_buf      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      o_gen_enable <= 1'b0;
      o_done       <= 1'b0;
      o_overflow   <= 1'b0;
    end else if (start) begin
      state        <= S_RUN;
      tile_total_q <= i_tile_total;
      tile_cnt     <= '0;
      lane_cnt     <= '0;
      row_cnt      <= '0;
      vld_sr       <= '0;
      pad_sr       <= '0;
      row_buf      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      o_gen_enable <= 1'b0;
      o_done       <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      vld_sr[0] <= word_in;
      pad_sr[0] <= i_pad;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        pad_sr[i] <= pad_sr[i-1];
      end

      if (word_vld) begin
        if (push_row) begin
          lane_cnt <= '0;
          row_cnt  <= last_row ? '0 : row_cnt + LW'(1);
          if (last_row) begin
            tile_cnt <= tile_cnt + 16'd1;
            if (last_tile) state <= S_DRAIN;
          end
          if (!push_ok) o_overflow <= 1'b1;
        end else begin
          lane_cnt <= lane_cnt + LW'(1);
          row_buf  <= row_next;
        end
      end

      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase

      if (pop && fifo_fin[rd_ptr]) o_done <= 1'b1;
      if (state == S_DRAIN && fifo_count == '0) state <= S_DONE;

      // Two free slots leave room for the one word the generator may emit after the drop.
      o_gen_enable <= run && (fifo_count <= CW'(FIFO_DEPTH-2)) && !(push_row && last_row && last_tile);
    end
  end

endmodule
